// File: rtl/led_pio_pkg.sv
// Shared register-map constants and sizing helper for the LED PWM/blink peripheral.
package led_pio_pkg;

  localparam int ADDR_DATA  = 0;
  localparam int ADDR_PRESC = 1;
  localparam int ADDR_BLINK = 2;
  localparam int ADDR_PWM   = 3;
  localparam int ADDR_DUTY0 = 4;

  // Four control words followed by one duty word per channel.
  function automatic int addr_w(input int num_ch);
    return $clog2(ADDR_DUTY0 + num_ch);
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// Per-channel gating: enable AND optional PWM compare AND optional blink phase.
module led_pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                data_i,
  input  logic                pwm_en_i,
  input  logic                blink_en_i,
  input  logic [PWM_BITS:0]   duty_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                blink_ph_i,
  output logic                on_o
);

  logic pwm_on;
  logic blink_on;

  // Compare one bit wider so a duty of 2^PWM_BITS is always on.
  assign pwm_on   = pwm_en_i ? ({1'b0, pwm_cnt_i} < duty_i) : 1'b1;
  assign blink_on = blink_en_i ? blink_ph_i : 1'b1;
  assign on_o     = data_i & pwm_on & blink_on;

endmodule

// File: rtl/led_pwm_pio.sv
// Avalon-MM LED peripheral: register file, shared prescaler/PWM counter/blink phase, registered LED outputs.
module led_pwm_pio
  import led_pio_pkg::*;
#(
  parameter int NUM_CH   = 10,
  parameter int PWM_BITS = 8,
  parameter int PRESC_W  = 16,
  parameter int ADDR_W   = addr_w(NUM_CH)
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic [NUM_CH-1:0] leds_export
);

  logic [NUM_CH-1:0]   data_q, blink_en_q, pwm_en_q;
  logic [PRESC_W-1:0]  presc_q;
  logic [PWM_BITS:0]   duty_q [NUM_CH];
  logic [PRESC_W-1:0]  presc_cnt_q, presc_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                blink_ph_q, blink_ph_d;
  logic [NUM_CH-1:0]   leds_q, on_vec;
  logic [31:0]         rdata_q, rdata_d;
  logic                tick, presc_wr, is_duty;
  logic [ADDR_W-1:0]   duty_idx;

  assign duty_idx = avs_address - ADDR_W'(ADDR_DUTY0);
  assign is_duty  = (avs_address >= ADDR_W'(ADDR_DUTY0)) && (duty_idx < ADDR_W'(NUM_CH));
  assign presc_wr = avs_write && (avs_address == ADDR_W'(ADDR_PRESC));
  assign tick     = (presc_cnt_q == presc_q);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      data_q     <= '0;
      presc_q    <= '0;
      blink_en_q <= '0;
      pwm_en_q   <= '0;
    end else if (avs_write) begin
      case (avs_address)
        ADDR_W'(ADDR_DATA):  data_q     <= avs_writedata[NUM_CH-1:0];
        ADDR_W'(ADDR_PRESC): presc_q    <= avs_writedata[PRESC_W-1:0];
        ADDR_W'(ADDR_BLINK): blink_en_q <= avs_writedata[NUM_CH-1:0];
        ADDR_W'(ADDR_PWM):   pwm_en_q   <= avs_writedata[NUM_CH-1:0];
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
          duty_q[gi] <= '0;
        end else if (avs_write && (avs_address == ADDR_W'(ADDR_DUTY0 + gi))) begin
          duty_q[gi] <= avs_writedata[PWM_BITS:0];
        end
      end

      led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
        .data_i     (data_q[gi]),
        .pwm_en_i   (pwm_en_q[gi]),
        .blink_en_i (blink_en_q[gi]),
        .duty_i     (duty_q[gi]),
        .pwm_cnt_i  (pwm_cnt_q),
        .blink_ph_i (blink_ph_q),
        .on_o       (on_vec[gi])
      );
    end
  endgenerate

  // A PRESCALE write restarts the tick interval; pwm_cnt and blink phase keep running.
  always_comb begin
    presc_cnt_d = presc_cnt_q + PRESC_W'(1);
    pwm_cnt_d   = pwm_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (tick) begin
      presc_cnt_d = '0;
      pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
      if (pwm_cnt_q == '1) blink_ph_d = ~blink_ph_q;
    end
    if (presc_wr) presc_cnt_d = '0;
  end

  always_comb begin
    rdata_d = '0;
    case (avs_address)
      ADDR_W'(ADDR_DATA):  rdata_d[NUM_CH-1:0]  = data_q;
      ADDR_W'(ADDR_PRESC): rdata_d[PRESC_W-1:0] = presc_q;
      ADDR_W'(ADDR_BLINK): rdata_d[NUM_CH-1:0]  = blink_en_q;
      ADDR_W'(ADDR_PWM):   rdata_d[NUM_CH-1:0]  = pwm_en_q;
      default: if (is_duty) rdata_d[PWM_BITS:0] = duty_q[duty_idx];
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
      blink_ph_q  <= 1'b0;
      leds_q      <= '0;
      rdata_q     <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_ph_q  <= blink_ph_d;
      leds_q      <= on_vec;
      if (avs_read) rdata_q <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign leds_export  = leds_q;

endmodule

// File: tb/tb_led_pwm_pio.sv
// Directed bench for led_pwm_pio at default parameters (10 channels, 8-bit PWM).
module tb_led_pwm_pio;

  localparam int NUM_CH = 10;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] avs_address = '0;
  logic              avs_read = 1'b0;
  logic              avs_write = 1'b0;
  logic [31:0]       avs_writedata = '0;
  logic [31:0]       avs_readdata;
  logic [NUM_CH-1:0] leds;

  int n_total = 0;
  int n_bad   = 0;

  led_pwm_pio #(.NUM_CH(NUM_CH), .PWM_BITS(8), .PRESC_W(16)) dut (
    .clk_clk       (clk),
    .reset_reset   (rst),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .leds_export   (leds)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic bus_wr(input logic [ADDR_W-1:0] a, input logic [31:0] v);
    @(negedge clk);
    avs_address = a; avs_writedata = v; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_rd(input logic [ADDR_W-1:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic count_high(input int cycles, output int hi);
    hi = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (leds[0] === 1'b1) hi++;
    end
  endtask

  task automatic read_all_zero(input string tag);
    logic [31:0] d;
    for (int a = 0; a < 14; a++) begin
      bus_rd(ADDR_W'(a), d);
      chk($sformatf("%s_rd%0d", tag, a), d, 32'h0);
    end
  endtask

  logic [31:0] rd;
  int          hi;
  int          edges [3];
  int          ne;
  logic        prev;

  initial begin
    // 1: reset state
    #23 rst = 1'b0;
    @(negedge clk);
    chk("rst_rdata", avs_readdata, 32'h0);
    chk("rst_leds", 32'(leds), 32'h0);
    read_all_zero("rst");

    // 2: DATA write truncation and write-to-pin latency
    bus_wr(4'd0, 32'hFFFF_FFFF);
    chk("data_leds_edgeN", 32'(leds), 32'h000);
    @(negedge clk);
    chk("data_leds_edgeN1", 32'(leds), 32'h3FF);
    bus_rd(4'd0, rd);  chk("data_rd", rd, 32'h0000_03FF);
    bus_rd(4'd15, rd); chk("unmapped15_rd", rd, 32'h0);
    bus_rd(4'd14, rd); chk("unmapped14_rd", rd, 32'h0);

    // 3: PWM duty 64/256, then full and zero duty
    bus_wr(4'd1, 32'd0);
    bus_wr(4'd4, 32'd64);
    bus_wr(4'd3, 32'h1);
    bus_wr(4'd0, 32'h1);
    @(negedge clk);
    count_high(256, hi); chk("pwm_duty64", hi, 64);
    count_high(256, hi); chk("pwm_duty64_again", hi, 64);
    chk("pwm_other_ch_off", 32'(leds[NUM_CH-1:1]), 32'h0);
    bus_wr(4'd4, 32'd256);
    @(negedge clk);
    count_high(256, hi); chk("pwm_duty256", hi, 256);
    bus_wr(4'd4, 32'd0);
    @(negedge clk);
    count_high(256, hi); chk("pwm_duty0", hi, 0);

    // 4: blink on channel 1 from a fresh reset, PRESCALE=1
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); #3 rst = 1'b0;
    bus_wr(4'd1, 32'd1);
    bus_wr(4'd2, 32'h2);
    bus_wr(4'd0, 32'h2);
    @(negedge clk);
    prev = leds[1];
    chk("blink_start_low", 32'(prev), 32'h0);
    ne = 0;
    edges[0] = 0; edges[1] = 0; edges[2] = 0;
    for (int c = 1; c <= 1700 && ne < 3; c++) begin
      @(negedge clk);
      if (leds[1] !== prev) begin
        if (ne == 0) chk("blink_first_rise", 32'(leds[1]), 32'h1);
        edges[ne] = c;
        ne++;
        prev = leds[1];
      end
    end
    chk("blink_edge_count", ne, 3);
    chk("blink_half_period_a", edges[1] - edges[0], 512);
    chk("blink_half_period_b", edges[2] - edges[1], 512);

    // 5: DUTY truncation and read-during-write
    bus_wr(4'd7, 32'hFFFF_FFFF);
    bus_rd(4'd7, rd); chk("duty3_rd", rd, 32'h1FF);
    @(negedge clk);
    avs_address = 4'd0; avs_writedata = 32'h0AA; avs_write = 1'b1; avs_read = 1'b1;
    @(negedge clk);
    avs_write = 1'b0; avs_read = 1'b0;
    chk("rw_same_old", avs_readdata, 32'h002);
    bus_rd(4'd0, rd); chk("rw_same_new", rd, 32'h0AA);

    // 6: asynchronous reset mid-period
    bus_wr(4'd1, 32'd0);
    bus_wr(4'd2, 32'h0);
    bus_wr(4'd3, 32'h1);
    bus_wr(4'd4, 32'd256);
    bus_wr(4'd0, 32'h1);
    @(negedge clk);
    chk("pre_async_leds", 32'(leds), 32'h1);
    @(negedge clk); #2 rst = 1'b1;
    #1 chk("async_rst_leds", 32'(leds), 32'h0);
    chk("async_rst_rdata", avs_readdata, 32'h0);
    @(negedge clk); #3 rst = 1'b0;
    read_all_zero("post");
    @(negedge clk);
    chk("post_leds", 32'(leds), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
